// File: rtl/ls_serial_pkg.sv
// Shared definitions for the LS-style serial transmitter.
// Holds the FSM state encodings and the fixed line levels of the frame.
package ls_serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/ls_baud_cnt.sv
// Baud counter for ls_serial_tx: counts 0..DIV-1 while EN is high.
// TICK marks the last cycle of a bit period. The count is held at 0 while EN is low.
module ls_baud_cnt
    import ls_serial_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic CP,
    input  logic CLR,
    input  logic EN,
    output logic TICK
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Free-running modulo-DIV count while a frame is active
    always_ff @(posedge CP or posedge CLR) begin
        if (CLR) begin
            cnt <= '0;
        end else if (!EN) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign TICK = (cnt == LAST);

endmodule

// File: rtl/ls_serial_tx.sv
// Parallel-in, serial-out frame transmitter (LS165-style shift path plus FSM).
// Frame: start bit (0), W data bits LSB first, optional even parity, stop bit (1).
// Each symbol lasts DIV clock cycles.
// Build option: define LS_SERIAL_TX_PARITY_EN to insert the parity symbol.
module ls_serial_tx
    import ls_serial_pkg::*;
#(
    parameter int W   = 8,
    parameter int DIV = 4
) (
    input  logic         CP,
    input  logic         CLR,
    input  logic         LOAD,
    input  logic [W-1:0] D,
    output logic         RDY,
    output logic         SO,
    output logic         BUSY,
    output logic         DONE
);

    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam logic [BW-1:0] LASTBIT = BW'(W - 1);

    state_t         state;
    logic [W-1:0]   sr;
    logic [W-1:0]   sr_nxt;
    logic [BW-1:0]  bitcnt;
    logic           tick;
    logic           baud_en;
`ifdef LS_SERIAL_TX_PARITY_EN
    logic           par;
`endif

    assign baud_en = (state != IDLE);
    assign sr_nxt  = sr >> 1;
    assign RDY     = (state == IDLE);

    ls_baud_cnt #(.DIV(DIV)) u_baud (
        .CP   (CP),
        .CLR  (CLR),
        .EN   (baud_en),
        .TICK (tick)
    );

    // Frame sequencing, shift register and registered line outputs
    always_ff @(posedge CP or posedge CLR) begin
        if (CLR) begin
            state  <= IDLE;
            sr     <= '0;
            bitcnt <= '0;
            SO     <= LINE_IDLE;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
`ifdef LS_SERIAL_TX_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    SO   <= LINE_IDLE;
                    BUSY <= 1'b0;
                    if (LOAD) begin
                        sr     <= D;
                        bitcnt <= '0;
                        state  <= START;
                        SO     <= START_BIT;
                        BUSY   <= 1'b1;
`ifdef LS_SERIAL_TX_PARITY_EN
                        par    <= ^D;
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        state <= DATA;
                        SO    <= sr[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        sr <= sr_nxt;
                        if (bitcnt == LASTBIT) begin
                            bitcnt <= '0;
`ifdef LS_SERIAL_TX_PARITY_EN
                            state  <= PARITY;
                            SO     <= par;
`else
                            state  <= STOP;
                            SO     <= STOP_BIT;
`endif
                        end else begin
                            bitcnt <= bitcnt + BW'(1);
                            SO     <= sr_nxt[0];
                        end
                    end
                end
`ifdef LS_SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state <= STOP;
                        SO    <= STOP_BIT;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        state <= IDLE;
                        SO    <= LINE_IDLE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    SO    <= LINE_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
